// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared fetch-stage constants and state encoding
package instr_fetch_unit_pkg;

    localparam int IF_ADDR_W = 16;
    localparam int IF_INSTR_W = 16;
    localparam logic [IF_INSTR_W-1:0] IF_NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory req/ack bus
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = IF_ADDR_W,
    parameter int INSTR_W = IF_INSTR_W
);
    logic               IMemReq;
    logic [ADDR_W-1:0]  IMemAddr;
    logic               IMemAck;
    logic [INSTR_W-1:0] IMemRdata;

    modport master (output IMemReq, IMemAddr, input IMemAck, IMemRdata);
    modport slave  (input IMemReq, IMemAddr, output IMemAck, IMemRdata);
endinterface

// File: rtl/fetch_hold_buffer.sv
// rtl/fetch_hold_buffer.sv - single-entry instruction/PC skid register
module fetch_hold_buffer #(
    parameter int ADDR_W = 16,
    parameter int INSTR_W = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage between PC register and IF/ID
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = IF_ADDR_W,
    parameter int INSTR_W = IF_INSTR_W,
    parameter int PC_INC = 1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [ADDR_W-1:0]   PCResult,
    output logic                PCWrite,
    input  logic                Stall,
    input  logic                Flush,
    instr_fetch_unit_if.master  imem,
    output logic                IFID_Valid,
    output logic [INSTR_W-1:0]  IFID_Instr,
    output logic [ADDR_W-1:0]   IFID_PC,
    output logic [ADDR_W-1:0]   IFID_PCInc
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  req_addr_q;
    logic               mem_load, hb_load, hb_clear, hb_drain;
    logic               hb_valid;
    logic [INSTR_W-1:0] hb_instr;
    logic [ADDR_W-1:0]  hb_pc;

    // Request is a pure decode of the state register, so reset drops it at once
    assign imem.IMemReq  = (state_q == WAIT) || (state_q == DROP);
    assign imem.IMemAddr = req_addr_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ISSUE;
            req_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ISSUE && !Flush) begin
                req_addr_q <= PCResult;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        PCWrite  = 1'b0;
        mem_load = 1'b0;
        hb_load  = 1'b0;
        hb_clear = 1'b0;
        hb_drain = 1'b0;
        case (state_q)
            ISSUE: begin
                if (Flush) PCWrite = 1'b1;
                else       state_d = WAIT;
            end
            WAIT: begin
                if (imem.IMemAck) begin
                    PCWrite = 1'b1;
                    state_d = ISSUE;
                    if (!Flush) begin
                        if (Stall) begin
                            hb_load = 1'b1;
                            state_d = HOLD;
                        end else begin
                            mem_load = 1'b1;
                        end
                    end
                end else if (Flush) begin
                    PCWrite = 1'b1;
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (Flush) begin
                    PCWrite  = 1'b1;
                    hb_clear = 1'b1;
                    state_d  = ISSUE;
                end else if (!Stall) begin
                    hb_drain = hb_valid;
                    hb_clear = 1'b1;
                    state_d  = ISSUE;
                end
            end
            DROP: begin
                if (Flush)        PCWrite = 1'b1;
                if (imem.IMemAck) state_d = ISSUE;
            end
            default: state_d = ISSUE;
        endcase
    end

    fetch_hold_buffer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_hold (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (hb_load),
        .clear    (hb_clear),
        .instr_in (imem.IMemRdata),
        .pc_in    (req_addr_q),
        .valid    (hb_valid),
        .instr    (hb_instr),
        .pc       (hb_pc)
    );

    // Flush beats Stall beats a new load; otherwise insert a bubble
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            IFID_Valid <= 1'b0;
            IFID_Instr <= NOP_INSTR;
            IFID_PC    <= '0;
            IFID_PCInc <= '0;
        end else if (Flush) begin
            IFID_Valid <= 1'b0;
            IFID_Instr <= NOP_INSTR;
        end else if (Stall) begin
            IFID_Valid <= IFID_Valid;
        end else if (mem_load) begin
            IFID_Valid <= 1'b1;
            IFID_Instr <= imem.IMemRdata;
            IFID_PC    <= req_addr_q;
            IFID_PCInc <= req_addr_q + INC;
        end else if (hb_drain) begin
            IFID_Valid <= 1'b1;
            IFID_Instr <= hb_instr;
            IFID_PC    <= hb_pc;
            IFID_PCInc <= hb_pc + INC;
        end else begin
            IFID_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit
module tb_instr_fetch_unit;

    typedef struct {
        logic [15:0] pc;
        logic        stall;
        logic        flush;
        logic        ack;
        logic [15:0] rdata;
        logic        pcw;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] instr;
        logic [15:0] ipc;
        logic [15:0] inc;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] PCResult = '0;
    logic        PCWrite;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        IFID_Valid;
    logic [15:0] IFID_Instr;
    logic [15:0] IFID_PC;
    logic [15:0] IFID_PCInc;

    int checks = 0;
    int failures = 0;

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .PCResult   (PCResult),
        .PCWrite    (PCWrite),
        .Stall      (Stall),
        .Flush      (Flush),
        .imem       (imem_bus),
        .IFID_Valid (IFID_Valid),
        .IFID_Instr (IFID_Instr),
        .IFID_PC    (IFID_PC),
        .IFID_PCInc (IFID_PCInc)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t v(input logic [15:0] pc, input logic st, input logic fl,
                               input logic ack, input logic [15:0] rd, input logic pcw,
                               input logic req, input logic [15:0] addr, input logic val,
                               input logic [15:0] ins, input logic [15:0] ipc,
                               input logic [15:0] inc);
        vec_t r;
        r.pc = pc; r.stall = st; r.flush = fl; r.ack = ack; r.rdata = rd;
        r.pcw = pcw; r.req = req; r.addr = addr; r.valid = val;
        r.instr = ins; r.ipc = ipc; r.inc = inc;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    vec_t vecs[30];

    initial begin
        imem_bus.IMemAck   = 1'b0;
        imem_bus.IMemRdata = '0;

        vecs[0]  = v(16'h0000,0,0,0,16'h0000, 0,0,16'h0000,0,16'h0000,16'h0000,16'h0000);
        vecs[1]  = v(16'h0000,0,0,1,16'h1234, 1,1,16'h0000,0,16'h0000,16'h0000,16'h0000);
        vecs[2]  = v(16'h0010,0,0,0,16'h0000, 0,0,16'h0000,1,16'h1234,16'h0000,16'h0001);
        vecs[3]  = v(16'h0010,0,0,0,16'h0000, 0,1,16'h0010,0,16'h1234,16'h0000,16'h0001);
        vecs[4]  = v(16'h0010,0,0,0,16'h0000, 0,1,16'h0010,0,16'h1234,16'h0000,16'h0001);
        vecs[5]  = v(16'h0010,0,0,0,16'h0000, 0,1,16'h0010,0,16'h1234,16'h0000,16'h0001);
        vecs[6]  = v(16'h0010,0,0,1,16'hA5A5, 1,1,16'h0010,0,16'h1234,16'h0000,16'h0001);
        vecs[7]  = v(16'h0020,0,0,0,16'h0000, 0,0,16'h0010,1,16'hA5A5,16'h0010,16'h0011);
        vecs[8]  = v(16'h0020,1,0,1,16'h5678, 1,1,16'h0020,0,16'hA5A5,16'h0010,16'h0011);
        vecs[9]  = v(16'h0020,1,0,0,16'h0000, 0,0,16'h0020,0,16'hA5A5,16'h0010,16'h0011);
        vecs[10] = v(16'h0020,1,0,0,16'h0000, 0,0,16'h0020,0,16'hA5A5,16'h0010,16'h0011);
        vecs[11] = v(16'h0020,0,0,0,16'h0000, 0,0,16'h0020,0,16'hA5A5,16'h0010,16'h0011);
        vecs[12] = v(16'h0030,0,0,0,16'h0000, 0,0,16'h0020,1,16'h5678,16'h0020,16'h0021);
        vecs[13] = v(16'h0030,0,1,0,16'h0000, 1,1,16'h0030,0,16'h5678,16'h0020,16'h0021);
        vecs[14] = v(16'h0100,0,1,0,16'h0000, 1,1,16'h0030,0,16'h0000,16'h0020,16'h0021);
        vecs[15] = v(16'h0100,0,0,1,16'hBEEF, 0,1,16'h0030,0,16'h0000,16'h0020,16'h0021);
        vecs[16] = v(16'h0100,0,0,0,16'h0000, 0,0,16'h0030,0,16'h0000,16'h0020,16'h0021);
        vecs[17] = v(16'h0100,0,0,1,16'h4321, 1,1,16'h0100,0,16'h0000,16'h0020,16'h0021);
        vecs[18] = v(16'h0110,1,1,0,16'h0000, 1,0,16'h0100,1,16'h4321,16'h0100,16'h0101);
        vecs[19] = v(16'h0110,0,0,0,16'h0000, 0,0,16'h0100,0,16'h0000,16'h0100,16'h0101);
        vecs[20] = v(16'h0110,0,1,1,16'h9999, 1,1,16'h0110,0,16'h0000,16'h0100,16'h0101);
        vecs[21] = v(16'h0200,0,0,0,16'h0000, 0,0,16'h0110,0,16'h0000,16'h0100,16'h0101);
        vecs[22] = v(16'h0200,1,0,1,16'h7777, 1,1,16'h0200,0,16'h0000,16'h0100,16'h0101);
        vecs[23] = v(16'h0200,0,1,0,16'h0000, 1,0,16'h0200,0,16'h0000,16'h0100,16'h0101);
        vecs[24] = v(16'h0300,0,0,1,16'hDEAD, 0,0,16'h0200,0,16'h0000,16'h0100,16'h0101);
        vecs[25] = v(16'h0300,0,0,0,16'h0000, 0,1,16'h0300,0,16'h0000,16'h0100,16'h0101);
        vecs[26] = v(16'h0300,0,0,1,16'h2222, 1,1,16'h0300,0,16'h0000,16'h0100,16'h0101);
        vecs[27] = v(16'hFFFF,0,0,0,16'h0000, 0,0,16'h0300,1,16'h2222,16'h0300,16'h0301);
        vecs[28] = v(16'hFFFF,0,0,1,16'h3333, 1,1,16'hFFFF,0,16'h2222,16'h0300,16'h0301);
        vecs[29] = v(16'h0040,0,0,0,16'h0000, 0,0,16'hFFFF,1,16'h3333,16'hFFFF,16'h0000);

        repeat (2) @(posedge Clk);
        #1;
        chk("rst_pcwrite", -1, 16'(PCWrite), 16'h0000);
        chk("rst_req",     -1, 16'(imem_bus.IMemReq), 16'h0000);
        chk("rst_addr",    -1, imem_bus.IMemAddr, 16'h0000);
        chk("rst_valid",   -1, 16'(IFID_Valid), 16'h0000);
        chk("rst_instr",   -1, IFID_Instr, 16'h0000);
        chk("rst_pc",      -1, IFID_PC, 16'h0000);
        chk("rst_pcinc",   -1, IFID_PCInc, 16'h0000);
        Reset = 1'b1;

        for (int i = 0; i < 30; i++) begin
            PCResult           = vecs[i].pc;
            Stall              = vecs[i].stall;
            Flush              = vecs[i].flush;
            imem_bus.IMemAck   = vecs[i].ack;
            imem_bus.IMemRdata = vecs[i].rdata;
            @(negedge Clk);
            chk("pcwrite", i, 16'(PCWrite), 16'(vecs[i].pcw));
            chk("req",     i, 16'(imem_bus.IMemReq), 16'(vecs[i].req));
            chk("addr",    i, imem_bus.IMemAddr, vecs[i].addr);
            chk("valid",   i, 16'(IFID_Valid), 16'(vecs[i].valid));
            chk("instr",   i, IFID_Instr, vecs[i].instr);
            chk("pc",      i, IFID_PC, vecs[i].ipc);
            chk("pcinc",   i, IFID_PCInc, vecs[i].inc);
            @(posedge Clk);
            #1;
        end

        // Asynchronous reset in the middle of a WAIT
        PCResult         = 16'h0040;
        imem_bus.IMemAck = 1'b0;
        @(negedge Clk);
        chk("wait_req",  30, 16'(imem_bus.IMemReq), 16'h0001);
        chk("wait_addr", 30, imem_bus.IMemAddr, 16'h0040);
        #2;
        Reset = 1'b0;
        #1;
        chk("arst_req",   31, 16'(imem_bus.IMemReq), 16'h0000);
        chk("arst_addr",  31, imem_bus.IMemAddr, 16'h0000);
        chk("arst_valid", 31, 16'(IFID_Valid), 16'h0000);
        chk("arst_instr", 31, IFID_Instr, 16'h0000);
        chk("arst_pc",    31, IFID_PC, 16'h0000);
        chk("arst_pcinc", 31, IFID_PCInc, 16'h0000);
        @(posedge Clk);
        #1;
        Reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
